// File: rtl/digit_scan_ctrl_if.sv
// Scan-controller bundle between the display sequencer and digit_scan_ctrl.
//   en        scan enable (master -> slave)
//   mask[3:0] digit include mask, bit i = digit i (master -> slave)
//   sel[1:0]  registered digit selector for the 2-to-4 decoder (slave -> master)
//   sel_valid sel is a live, unmasked digit being displayed (slave -> master)
//   tick      one-cycle pulse when sel takes a new value (slave -> master)
//   frame     one-cycle pulse with tick when the scan wraps (slave -> master)
interface digit_scan_ctrl_if;
  logic       en;
  logic [3:0] mask;
  logic [1:0] sel;
  logic       sel_valid;
  logic       tick;
  logic       frame;

  modport master (
    output en,
    output mask,
    input  sel,
    input  sel_valid,
    input  tick,
    input  frame
  );

  modport slave (
    input  en,
    input  mask,
    output sel,
    output sel_valid,
    output tick,
    output frame
  );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexing scan controller for a 4-digit display. Steps a 2-bit
// digit selector through the enabled digits, dwelling DIV clocks on each,
// skipping masked digits, and pulses tick on every selector change and frame
// when the advance wraps.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   scan_io  digit_scan_ctrl_if.slave: en, mask in; sel, sel_valid, tick, frame out
//
// Parameters: DIV_W prescaler width, DIV clocks per dwell (2..2^DIV_W-1),
//             BLANK inter-digit blanking clocks (>= 1, blanking build only).
//
// Build option: define SCAN_BLANK_EN to insert BLANK clocks of sel_valid=0
// after every advance. Without it the BLANK state and counter are absent.
module digit_scan_ctrl #(
  parameter int unsigned DIV_W = 16,
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 4
) (
  input logic               clk,
  input logic               rst,
  digit_scan_ctrl_if.slave  scan_io
);

  if (DIV < 2 || DIV > (2 ** DIV_W) - 1 || BLANK < 1) begin : g_bad_cfg
    $error("digit_scan_ctrl: illegal DIV/BLANK configuration");
  end

  localparam logic [DIV_W-1:0] DivLast = DIV_W'(DIV - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShow,
    StBlank
  } state_e;

  state_e           state_q;
  logic [DIV_W-1:0] prescaler_q;
  logic [1:0]       sel_q;
  logic             sel_valid_q;
  logic             tick_q;
  logic             frame_q;

`ifdef SCAN_BLANK_EN
  localparam int unsigned BlankW = (BLANK > 1) ? $clog2(BLANK) : 1;
  localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK - 1);
  logic [BlankW-1:0] blank_cnt_q;
`endif

  logic       any_en;
  logic [1:0] low_idx;
  logic [1:0] nxt_idx;

  // low_idx: lowest enabled digit. nxt_idx: next enabled digit strictly above
  // sel_q, falling back to low_idx (wrap). Both are 0 when mask is empty.
  always_comb begin
    any_en  = |scan_io.mask;
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (scan_io.mask[i]) low_idx = 2'(i);
    end
    nxt_idx = low_idx;
    for (int i = 3; i >= 0; i--) begin
      if (scan_io.mask[i] && (i > int'(sel_q))) nxt_idx = 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      prescaler_q <= '0;
      sel_q       <= 2'd0;
      sel_valid_q <= 1'b0;
      tick_q      <= 1'b0;
      frame_q     <= 1'b0;
`ifdef SCAN_BLANK_EN
      blank_cnt_q <= '0;
`endif
    end else begin
      tick_q  <= 1'b0;
      frame_q <= 1'b0;
      if (!scan_io.en) begin
        // sel deliberately holds so the decoder output does not glitch.
        state_q     <= StIdle;
        prescaler_q <= '0;
        sel_valid_q <= 1'b0;
`ifdef SCAN_BLANK_EN
        blank_cnt_q <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q     <= StShow;
            prescaler_q <= '0;
            sel_q       <= low_idx;
            tick_q      <= any_en;
            sel_valid_q <= scan_io.mask[low_idx];
          end
          StShow: begin
            if (prescaler_q == DivLast) begin
              prescaler_q <= '0;
              // Empty mask: selector holds and no pulses.
              if (any_en) begin
                sel_q   <= nxt_idx;
                tick_q  <= 1'b1;
                frame_q <= (nxt_idx <= sel_q);
              end
`ifdef SCAN_BLANK_EN
              state_q     <= StBlank;
              blank_cnt_q <= '0;
              sel_valid_q <= 1'b0;
`else
              sel_valid_q <= scan_io.mask[nxt_idx];
`endif
            end else begin
              prescaler_q <= prescaler_q + 1'b1;
              sel_valid_q <= scan_io.mask[sel_q];
            end
          end
`ifdef SCAN_BLANK_EN
          StBlank: begin
            if (blank_cnt_q == BlankLast) begin
              state_q     <= StShow;
              prescaler_q <= '0;
              sel_valid_q <= scan_io.mask[sel_q];
            end else begin
              blank_cnt_q <= blank_cnt_q + 1'b1;
            end
          end
`endif
          default: begin
            state_q     <= StIdle;
            prescaler_q <= '0;
            sel_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign scan_io.sel       = sel_q;
  assign scan_io.sel_valid = sel_valid_q;
  assign scan_io.tick      = tick_q;
  assign scan_io.frame     = frame_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Scoreboard bench for digit_scan_ctrl: the driver applies inputs on the
// falling edge and queues the outputs a behavioural model predicts for the
// next rising edge; the monitor pops and compares just after each rising edge.
module tb_digit_scan_ctrl;
  localparam int Div   = 4;
  localparam int Blank = 2;
`ifdef SCAN_BLANK_EN
  localparam int BlankCyc = Blank;
`else
  localparam int BlankCyc = 0;
`endif

  logic clk = 1'b0;
  logic rst;

  digit_scan_ctrl_if scan_if ();

  digit_scan_ctrl #(
    .DIV_W (8),
    .DIV   (Div),
    .BLANK (Blank)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .scan_io (scan_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       sel_valid;
    logic       tick;
    logic       frame;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: scanning or not, shown digit, clocks left in the current
  // dwell, clocks left in the current blanking gap.
  bit m_active     = 1'b0;
  int m_sel        = 0;
  int m_dwell_left = 0;
  int m_blank_left = 0;

  // First enabled digit found walking upward from start, wrapping mod 4.
  function automatic int first_from(input int start, input logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input bit r, input bit e, input logic [3:0] m, output exp_t x);
    int old;
    x.tick  = 1'b0;
    x.frame = 1'b0;
    x.sel_valid = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_sel    = 0;
    end else if (!e) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active     = 1'b1;
      m_dwell_left = Div;
      m_blank_left = 0;
      if (m != 4'd0) begin
        m_sel  = first_from(0, m);
        x.tick = 1'b1;
      end else begin
        m_sel = 0;
      end
      x.sel_valid = m[m_sel];
    end else if (m_blank_left > 0) begin
      m_blank_left--;
      if (m_blank_left == 0) begin
        m_dwell_left = Div;
        x.sel_valid  = m[m_sel];
      end
    end else begin
      m_dwell_left--;
      if (m_dwell_left == 0) begin
        if (m != 4'd0) begin
          old     = m_sel;
          m_sel   = first_from(m_sel + 1, m);
          x.tick  = 1'b1;
          x.frame = (m_sel <= old);
        end
        m_dwell_left = Div;
        m_blank_left = BlankCyc;
        x.sel_valid  = (BlankCyc == 0) && m[m_sel];
      end else begin
        x.sel_valid = m[m_sel];
      end
    end
    x.sel = 2'(m_sel);
  endtask

  task automatic drive(input bit r, input bit e, input logic [3:0] m);
    exp_t x;
    @(negedge clk);
    rst          = r;
    scan_if.en   = e;
    scan_if.mask = m;
    model_step(r, e, m, x);
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("sel",       scan_if.sel,               x.sel);
        check("sel_valid", {1'b0, scan_if.sel_valid}, {1'b0, x.sel_valid});
        check("tick",      {1'b0, scan_if.tick},      {1'b0, x.tick});
        check("frame",     {1'b0, scan_if.frame},     {1'b0, x.frame});
      end
    end
  end

  initial begin
    logic [3:0] mask_r;
    bit         en_r;
    rst          = 1'b1;
    scan_if.en   = 1'b0;
    scan_if.mask = 4'd0;

    drive(1'b1, 1'b0, 4'd0);
    drive(1'b1, 1'b1, 4'hF);
    // Full scan, then a sparse mask.
    for (int i = 0; i < 22; i++) drive(1'b0, 1'b1, 4'b1111);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 4'b0101);
    // Empty mask, then only digit 3.
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'b1000);
    // Drop en mid-dwell on digit 2, then restart.
    for (int i = 0; i < 40 && !(m_active && m_sel == 2 && m_blank_left == 0 &&
                                m_dwell_left == Div - 2); i++)
      drive(1'b0, 1'b1, 4'b1111);
    drive(1'b0, 1'b0, 4'b1111);
    drive(1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 4'b1111);
    // Reset on digit 2 with prescaler at 1.
    for (int i = 0; i < 40 && !(m_active && m_sel == 2 && m_blank_left == 0 &&
                                m_dwell_left == Div - 1); i++)
      drive(1'b0, 1'b1, 4'b1111);
    drive(1'b1, 1'b1, 4'b1111);
    drive(1'b0, 1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 4'b0001);

    // Randomised traffic: mostly enabled, occasional mask changes and resets.
    mask_r = 4'b1011;
    en_r   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) mask_r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) en_r = ~en_r;
      else if (!en_r && $urandom_range(0, 3) == 0) en_r = 1'b1;
      drive(($urandom_range(0, 199) == 0), en_r, mask_r);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexing scan controller that generates the 2-bit digit selector consumed by the team's 2-to-4 one-hot decoder. It sits directly upstream of that decoder in the 4-digit display path. It steps through the four digit positions at a programmable dwell rate, skips masked digits, and flags selector changes and frame wrap for the segment-data path.

## Interface
- DIV_W, 16: prescaler counter width.
- DIV, 50000: clocks per digit dwell; legal range 2 ≤ DIV ≤ 2^DIV_W−1.
- BLANK, 4: inter-digit blanking clocks, used only with SCAN_BLANK_EN; legal minimum 1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable.
- mask  in  4  digit enable; bit i = 1 includes digit i in the scan.
- sel  out  2  registered digit selector; drives the decoder select input.
- sel_valid  out  1  registered; 1 when sel is a live, unmasked digit being displayed.
- tick  out  1  one-cycle pulse in the cycle sel takes a new value.
- frame  out  1  one-cycle pulse coincident with tick when the advance wraps (new sel ≤ old sel).

## Operation
- States: IDLE, SHOW, BLANK. BLANK is reachable only with SCAN_BLANK_EN.
- Reset: state=IDLE, prescaler=0, sel=0, sel_valid=0, tick=0, frame=0. rst overrides en and mask.
- IDLE with en=1: next cycle state=SHOW, prescaler=0, sel=lowest set bit of mask, tick=1.
  - If mask=0: sel=0, tick=0.
- SHOW: the prescaler increments each clock. At prescaler=DIV−1 the block advances:
  - prescaler←0.
  - sel←next enabled index above sel, else the lowest enabled index (wrap 3→0 order).
  - tick=1.
  - frame=1 if new sel ≤ old sel. A single enabled digit therefore produces tick and frame on every advance.
- Advance with mask=0: sel holds, tick=0, frame=0, prescaler restarts.
- sel_valid←(next state==SHOW) && mask[next sel] && en. It is registered, so mask changes show on sel_valid one cycle later. The selector moves only at an advance.
- en=0 in any state: next cycle state=IDLE, prescaler=0, sel_valid=0. sel holds. No tick or frame.
- A mask change never truncates a dwell. It affects only the next advance target and sel_valid.

## Timing
- Advance edge: the edge where SHOW and prescaler=DIV−1. On the following cycle, sel, tick and frame are updated.
- Without blanking, every digit shows for exactly DIV cycles. The scan period with k enabled digits is k·DIV cycles.
- tick and frame are high for exactly one cycle and never asserted in IDLE.
- Latency:
  - en rising to sel_valid=1: 1 cycle.
  - en falling to sel_valid=0: 1 cycle.
  - rst to all outputs zero: 1 cycle.

## Configuration
- SCAN_BLANK_EN defined:
  - At an advance, the block enters BLANK. sel updates and tick/frame pulse as normal, but sel_valid=0.
  - After BLANK cycles it enters SHOW with prescaler=0 and sel_valid per the rule above.
  - Per-digit period is BLANK+DIV. The first SHOW after IDLE is not preceded by BLANK.
  - en=0 or rst during BLANK goes to IDLE or reset as normal.
- SCAN_BLANK_EN undefined: BLANK state and its counter are absent, the BLANK parameter is ignored, and advances go SHOW→SHOW.

## Test plan
- rst, then en=1, mask=1111, DIV=4 -> sel 0,1,2,3,0 each held 4 cycles. tick at each change. frame only on 3→0. sel_valid=1 throughout.
- mask=0101, DIV=4 -> sel alternates 0,2,0,2 every 4 cycles. frame on each 2→0. Digits 1 and 3 never selected.
- en=1, mask=0000 -> sel_valid=0, no tick for 20 cycles. Set mask=1000 -> at the next advance sel=3, tick=1, frame=0, and sel_valid=1 the same cycle.
- At sel=2, drop en mid-dwell -> next cycle sel_valid=0, sel=2. Re-raise en with mask=1111 -> next cycle sel=0, tick=1, sel_valid=1, and a full 4-cycle dwell follows.
- At sel=2 with prescaler=1, assert rst for one cycle -> next cycle sel=0, sel_valid=0, tick=0, frame=0, state IDLE.
- SCAN_BLANK_EN, DIV=4, BLANK=2, mask=1111 -> each advance gives 2 cycles of sel_valid=0 with the new sel, then 4 cycles of sel_valid=1. Period is 6 cycles per digit.
